mc_ctrl_fsm: RTL

- Multi-cycle control unit for the 32-bit processor datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the 2-bit ALU operation select and the datapath enables.
- Samples the ALU Zero/Carry flags to resolve conditional branches, and stalls on a memory ready handshake.

---
 rtl/mc_pkg.sv | 64 ++++++
 rtl/mc_branch_eval.sv | 23 ++
 rtl/mc_ctrl_fsm.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// Opcode map, ALU/PC select codes, state encoding and instruction classifier.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [4:0] OP_AND  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_ANDI = 5'd3;
  localparam logic [4:0] OP_ADDI = 5'd4;
  localparam logic [4:0] OP_LW   = 5'd5;
  localparam logic [4:0] OP_SW   = 5'd6;
  localparam logic [4:0] OP_BEQ  = 5'd7;
  localparam logic [4:0] OP_BNE  = 5'd8;
  localparam logic [4:0] OP_BGT  = 5'd9;
  localparam logic [4:0] OP_BLT  = 5'd10;
  localparam logic [4:0] OP_J    = 5'd11;
  localparam logic [4:0] OP_HALT = 5'd12;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_NOP = 2'b11;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    C_RTYPE,
    C_ANDI,
    C_ADDI,
    C_LW,
    C_SW,
    C_BRANCH,
    C_JUMP,
    C_HALT,
    C_ILLEGAL
  } iclass_t;

  function automatic iclass_t op_class(input logic [4:0] op);
    case (op)
      OP_AND, OP_ADD, OP_SUB:         return C_RTYPE;
      OP_ANDI:                        return C_ANDI;
      OP_ADDI:                        return C_ADDI;
      OP_LW:                          return C_LW;
      OP_SW:                          return C_SW;
      OP_BEQ, OP_BNE, OP_BGT, OP_BLT: return C_BRANCH;
      OP_J:                           return C_JUMP;
      OP_HALT:                        return C_HALT;
      default:                        return C_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mc_branch_eval.sv
// Conditional-branch resolver: opcode plus ALU Zero/Carry flags -> taken.
// Non-branch opcodes always report not-taken.
module mc_branch_eval
  import mc_pkg::*;
(
  input  logic [4:0] op,
  input  logic       zero_flag,
  input  logic       carry_flag,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = zero_flag;
      OP_BNE:  taken = ~zero_flag;
      OP_BGT:  taken = ~zero_flag & carry_flag;
      OP_BLT:  taken = ~zero_flag & ~carry_flag;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with HALT/TRAP.
// Optional performance counters enabled by defining MC_PERF_CNT_EN.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int unsigned OPW  = 5,
  parameter int unsigned ST_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero_flag,
  input  logic            carry_flag,
  input  logic            mem_ready,
  output logic [1:0]      alu_op,
  output logic            alu_src_b,
  output logic            alu_src_a,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            iord,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic [ST_W-1:0] state,
  output logic            halted,
  output logic            trap
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     instr_cnt
`endif
);

  state_t      state_q;
  state_t      state_d;
  iclass_t     cls;
  logic        br_taken;
  logic [OPW+4:0] op_ext;
  logic [4:0]  op_lo;

  // Zero-extend so any opcode width works; set bits above bit 4 make it illegal.
  assign op_ext = {5'b0, opcode};
  assign op_lo  = op_ext[4:0];
  assign cls    = (|op_ext[OPW+4:5]) ? C_ILLEGAL : op_class(op_lo);

  mc_branch_eval u_branch_eval (
    .op         (op_lo),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .taken      (br_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state = ST_W'(state_q);

  always_comb begin
    state_d    = state_q;
    alu_op     = ALU_NOP;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_INC;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    halted     = 1'b0;
    trap       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_op   = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_INC;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        case (cls)
          C_JUMP: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            state_d  = S_FETCH;
          end
          C_HALT:    state_d = S_HALT;
          C_ILLEGAL: state_d = S_TRAP;
          default:   state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        case (cls)
          C_RTYPE: begin
            case (op_lo)
              OP_AND:  alu_op = ALU_AND;
              OP_SUB:  alu_op = ALU_SUB;
              default: alu_op = ALU_ADD;
            endcase
            state_d = S_WB;
          end
          C_ANDI: begin
            alu_op    = ALU_AND;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          C_ADDI: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          C_LW, C_SW: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          C_BRANCH: begin
            alu_op = ALU_SUB;
            if (br_taken) begin
              pc_write = 1'b1;
              pc_src   = PC_BRANCH;
            end
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        iord      = 1'b1;
        mem_read  = (cls == C_LW);
        mem_write = (cls == C_SW);
        if (mem_ready) state_d = (cls == C_LW) ? S_WB : S_FETCH;
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == C_LW);
        reg_dst    = (cls == C_RTYPE);
        state_d    = S_FETCH;
      end

      S_HALT: halted = 1'b1;
      S_TRAP: trap   = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Reset masks every output at once, so nothing strobes while held or on release.
    if (!rst_n) begin
      alu_op     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      halted     = 1'b0;
      trap       = 1'b0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic instr_done;

  assign instr_done = ((state_d == S_FETCH) && (state_q != S_FETCH)) ||
                      ((state_d == S_HALT)  && (state_q != S_HALT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      if ((state_q != S_HALT) && (state_q != S_TRAP)) cyc_cnt <= cyc_cnt + 32'd1;
      if (instr_done) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule
